// File: rtl/spi_sclk_gen.sv
// spi_sclk_gen
// Runtime-programmable SPI serial-clock generator. Each accepted request
// produces a burst of exactly nbits SCLK cycles in any CPOL/CPHA mode. The
// burst is framed by one half-period of idle-level SCLK before the first
// edge and one after the last edge. Single-cycle sample/shift strobes are
// issued in the clk domain, so the data path can stay fully synchronous.
//
// Ports:
//   clk        system clock; all logic on the rising edge
//   reset      asynchronous, active-high; clears all state
//   div        half-period select; SCLK half-period H = div+1 clk cycles
//   cpol       SCLK idle level
//   cpha       0: sample on leading edge, shift on trailing; 1: reverse
//   nbits      SCLK cycles per burst (0 gives an immediate done, no burst)
//   start      request; accepted on a clk edge where busy=0
//   busy       burst in progress
//   done       one-cycle pulse at burst end
//   sclk       serial clock, registered
//   sample_stb one-cycle pulse in the cycle sclk shows a sampling edge
//   shift_stb  one-cycle pulse in the cycle sclk shows a shifting edge

module spi_sclk_gen #(
  parameter int DIV_W = 8,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DIV_W-1:0] div,
  input  logic             cpol,
  input  logic             cpha,
  input  logic [CNT_W-1:0] nbits,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             sclk,
  output logic             sample_stb,
  output logic             shift_stb
);

  typedef enum logic [1:0] {
    IDLE,
    LEAD,
    ACTIVE,
    TRAIL
  } state_t;

  state_t state;
  state_t state_next;

  // Burst configuration, frozen for the whole burst
  logic [DIV_W-1:0] div_r;
  logic             cpha_r;
  logic [CNT_W-1:0] nbits_r;

  logic [DIV_W-1:0] half_cnt;
  // One bit wider than nbits so that 2*nbits always fits
  logic [CNT_W:0]   edge_cnt;

  logic             half_done;
  logic [CNT_W:0]   edge_next;
  logic             last_edge;
  logic             sample_next;

  assign busy = (state != IDLE);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and edge bookkeeping
  always_comb begin
    state_next  = state;
    half_done   = (half_cnt == div_r);
    edge_next   = edge_cnt + 1'b1;
    last_edge   = (edge_next == {nbits_r, 1'b0});
    // Odd edges are leading; cpha swaps which edge kind samples
    sample_next = edge_next[0] ^ cpha_r;
    case (state)
      IDLE:    if (start && (nbits != '0)) state_next = LEAD;
      LEAD:    if (half_done) state_next = ACTIVE;
      ACTIVE:  if (half_done && last_edge) state_next = TRAIL;
      TRAIL:   if (half_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Counters, latched configuration and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_r      <= '0;
      cpha_r     <= 1'b0;
      nbits_r    <= '0;
      half_cnt   <= '0;
      edge_cnt   <= '0;
      sclk       <= 1'b0;
      done       <= 1'b0;
      sample_stb <= 1'b0;
      shift_stb  <= 1'b0;
    end else begin
      done       <= 1'b0;
      sample_stb <= 1'b0;
      shift_stb  <= 1'b0;
      case (state)
        IDLE: begin
          // Idle level tracks cpol with a one-cycle lag
          sclk     <= cpol;
          half_cnt <= '0;
          edge_cnt <= '0;
          if (start) begin
            div_r   <= div;
            cpha_r  <= cpha;
            nbits_r <= nbits;
            // Zero-length request completes without ever going busy
            if (nbits == '0) done <= 1'b1;
          end
        end
        LEAD, ACTIVE: begin
          // The edge leaving LEAD is SCLK edge 1; all later edges come from ACTIVE
          if (half_done) begin
            half_cnt   <= '0;
            edge_cnt   <= edge_next;
            sclk       <= ~sclk;
            sample_stb <= sample_next;
            shift_stb  <= ~sample_next;
          end else begin
            half_cnt <= half_cnt + 1'b1;
          end
        end
        TRAIL: begin
          if (half_done) begin
            half_cnt <= '0;
            done     <= 1'b1;
          end else begin
            half_cnt <= half_cnt + 1'b1;
          end
        end
        default: begin
          half_cnt <= '0;
          edge_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_sclk_gen.sv
// tb_spi_sclk_gen
// Self-checking bench for spi_sclk_gen. A table of burst configurations with
// hand-computed done cycle and strobe counts is run in a loop. Every cycle is
// compared against a timing model built from the burst-length formulas.
// Hand-written sequences then cover the multi-cycle corner cases: ignored
// start while busy, back-to-back starts, mid-burst parameter changes and
// asynchronous reset during a burst.

module tb_spi_sclk_gen;

  localparam int DIV_W = 8;
  localparam int CNT_W = 6;

  typedef struct {
    int div;
    bit cpol;
    bit cpha;
    int nbits;
    int expDone;
    int expSamples;
    int expShifts;
  } vec_t;

  logic             clk = 1'b0;
  logic             reset;
  logic [DIV_W-1:0] div;
  logic             cpol;
  logic             cpha;
  logic [CNT_W-1:0] nbits;
  logic             start;
  logic             busy;
  logic             done;
  logic             sclk;
  logic             sample_stb;
  logic             shift_stb;

  int numChecks = 0;
  int numFails  = 0;

  vec_t vecs[7];

  spi_sclk_gen #(.DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .div        (div),
    .cpol       (cpol),
    .cpha       (cpha),
    .nbits      (nbits),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .sclk       (sclk),
    .sample_stb (sample_stb),
    .shift_stb  (shift_stb)
  );

  always #5 clk = ~clk;

  // Expected {busy, done, sclk, sample_stb, shift_stb} in cycle c after a
  // start accepted at edge 0
  function automatic logic [4:0] modelOut(input int c, input int d, input bit cp,
                                          input bit ch, input int n);
    int  h;
    int  len;
    int  edges;
    int  k;
    bit  bsy;
    bit  dn;
    bit  sc;
    bit  smp;
    bit  shf;
    h   = d + 1;
    len = (2 * n + 1) * h;
    smp = 1'b0;
    shf = 1'b0;
    if (n == 0) begin
      bsy = 1'b0;
      dn  = (c == 1);
      sc  = cp;
    end else begin
      bsy   = (c >= 1) && (c <= len);
      dn    = (c == len + 1);
      edges = (c >= h + 1) ? (c - 1) / h : 0;
      if (edges > 2 * n) edges = 2 * n;
      sc = cp ^ (edges % 2 == 1);
      k  = (c - 1) / h;
      if (((c - 1) % h == 0) && (k >= 1) && (k <= 2 * n)) begin
        smp = (k % 2 == 1) ^ ch;
        shf = !smp;
      end
    end
    return {bsy, dn, sc, smp, shf};
  endfunction

  task automatic checkOutput(input string name, input int cyc,
                             input logic [31:0] act, input logic [31:0] exp);
    numChecks++;
    if (act !== exp) begin
      numFails++;
      $display("[TB] FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Drive a configuration and pulse start so it is sampled at the next edge
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    div   = DIV_W'(v.div);
    cpol  = v.cpol;
    cpha  = v.cpha;
    nbits = CNT_W'(v.nbits);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Check every cycle of a burst whose start was just accepted. Optionally
  // pulse start (and change parameters) mid-burst, and optionally raise start
  // in the done cycle with nextV so the caller can chain a second burst.
  task automatic runBurst(input vec_t v, input string tag, input int pokeCycle,
                          input bit pokeChange, input bit chain, input vec_t nextV);
    int doneAt;
    int smp;
    int shf;
    int last;
    logic [4:0] obs;
    logic [4:0] expv;
    doneAt = 0;
    smp    = 0;
    shf    = 0;
    last   = (v.nbits == 0) ? 1 : (2 * v.nbits + 1) * (v.div + 1) + 1;
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      obs  = {busy, done, sclk, sample_stb, shift_stb};
      expv = modelOut(c, v.div, v.cpol, v.cpha, v.nbits);
      checkOutput({tag, " outputs"}, c, 32'(obs), 32'(expv));
      if (done && (doneAt == 0)) doneAt = c;
      smp += int'(sample_stb);
      shf += int'(shift_stb);
      start = 1'b0;
      if (c == pokeCycle) begin
        start = 1'b1;
        if (pokeChange) begin
          div   = DIV_W'(nextV.div);
          cpol  = nextV.cpol;
          cpha  = nextV.cpha;
          nbits = CNT_W'(nextV.nbits);
        end
      end
      if ((c == last) && chain) begin
        div   = DIV_W'(nextV.div);
        cpol  = nextV.cpol;
        cpha  = nextV.cpha;
        nbits = CNT_W'(nextV.nbits);
        start = 1'b1;
      end
    end
    checkOutput({tag, " done cycle"}, last, 32'(doneAt), 32'(v.expDone));
    checkOutput({tag, " sample count"}, last, 32'(smp), 32'(v.expSamples));
    checkOutput({tag, " shift count"}, last, 32'(shf), 32'(v.expShifts));
  endtask

  initial begin
    vec_t a;
    vec_t b;
    vec_t c0;
    vec_t d0;
    vec_t r;
    logic [4:0] expv;

    // {div, cpol, cpha, nbits, done cycle, samples, shifts}
    vecs[0] = '{3, 1'b0, 1'b0, 8, 69, 8, 8};
    vecs[1] = '{0, 1'b1, 1'b1, 2, 6, 2, 2};
    vecs[2] = '{0, 1'b0, 1'b0, 0, 1, 0, 0};
    vecs[3] = '{2, 1'b1, 1'b0, 3, 22, 3, 3};
    vecs[4] = '{0, 1'b0, 1'b1, 1, 4, 1, 1};
    vecs[5] = '{5, 1'b1, 1'b1, 1, 19, 1, 1};
    vecs[6] = '{1, 1'b0, 1'b1, 4, 19, 4, 4};

    reset = 1'b1;
    start = 1'b0;
    div   = '0;
    cpol  = 1'b1;
    cpha  = 1'b0;
    nbits = '0;
    #12;
    checkOutput("reset state", 0, 32'({busy, done, sclk, sample_stb, shift_stb}), 32'd0);

    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("idle sclk follows cpol=1", 0, 32'(sclk), 32'd1);
    cpol = 1'b0;
    #1;
    checkOutput("idle sclk lags cpol", 0, 32'(sclk), 32'd1);
    @(negedge clk);
    checkOutput("idle sclk follows cpol=0", 0, 32'(sclk), 32'd0);

    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i]);
      runBurst(vecs[i], $sformatf("vec%0d", i), 0, 1'b0, 1'b0, vecs[i]);
    end

    // Start while busy is ignored; start in the done cycle chains a burst
    a = '{1, 1'b0, 1'b0, 4, 19, 4, 4};
    b = '{2, 1'b0, 1'b1, 2, 16, 2, 2};
    applyStimulus(a);
    runBurst(a, "ignored start", 7, 1'b0, 1'b1, b);
    @(posedge clk);
    #1;
    start = 1'b0;
    runBurst(b, "back-to-back", 0, 1'b0, 1'b0, b);

    // Parameter changes mid-burst only apply to the next burst
    c0 = '{3, 1'b0, 1'b0, 8, 69, 8, 8};
    d0 = '{0, 1'b1, 1'b0, 3, 8, 3, 3};
    applyStimulus(c0);
    runBurst(c0, "mid-burst change", 20, 1'b1, 1'b0, d0);
    @(negedge clk);
    checkOutput("idle sclk after change", 0, 32'(sclk), 32'd1);
    applyStimulus(d0);
    runBurst(d0, "new params", 0, 1'b0, 1'b0, d0);

    // Asynchronous reset in cycle 10 of a burst
    r = '{3, 1'b1, 1'b0, 8, 69, 8, 8};
    applyStimulus(r);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      expv = modelOut(c, r.div, r.cpol, r.cpha, r.nbits);
      checkOutput("pre-reset outputs", c, 32'({busy, done, sclk, sample_stb, shift_stb}), 32'(expv));
    end
    #1;
    reset = 1'b1;
    #1;
    checkOutput("async reset clears outputs", 10, 32'({busy, done, sclk, sample_stb, shift_stb}), 32'd0);
    for (int c = 11; c <= 13; c++) begin
      @(negedge clk);
      checkOutput("held in reset", c, 32'({busy, done, sclk, sample_stb, shift_stb}), 32'd0);
    end
    reset = 1'b0;
    @(negedge clk);
    checkOutput("no done after reset", 0, 32'({busy, done}), 32'd0);
    applyStimulus(r);
    runBurst(r, "after reset", 0, 1'b0, 1'b0, r);

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
